// File: rtl/phase_delay_meter.sv
// Single-shot meter for the delay from a reference PWM rising edge to the next
// rising edge of a delayed copy, plus the reference period, in clk cycles.
module phase_delay_meter #(
  parameter int CTR_W       = 18,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ref_in,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic [CTR_W-1:0] delay,
  output logic [CTR_W-1:0] period,
  output logic             valid,
  output logic             err
);

  typedef enum logic [2:0] {IDLE, ARM, MEASURE, PERIOD, DONE} state_t;

  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  state_t             state, state_nxt;
  logic [SYNC_STAGES-1:0] ref_sync, sig_sync;
  logic               ref_prev, sig_prev;
  logic               rise_ref, rise_sig;
  logic [CTR_W-1:0]   cnt, cnt_nxt;
  logic [CTR_W-1:0]   d_q, d_nxt, p_q, p_nxt;
  logic               flag_q, flag_nxt;

  // Both inputs see the same synchronizer depth, so edge-to-edge counts are exact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_sync <= '0;
      sig_sync <= '0;
      ref_prev <= 1'b0;
      sig_prev <= 1'b0;
    end else begin
      ref_sync <= {ref_sync[SYNC_STAGES-2:0], ref_in};
      sig_sync <= {sig_sync[SYNC_STAGES-2:0], sig_in};
      ref_prev <= ref_sync[SYNC_STAGES-1];
      sig_prev <= sig_sync[SYNC_STAGES-1];
    end
  end

  assign rise_ref = ref_sync[SYNC_STAGES-1] & ~ref_prev;
  assign rise_sig = sig_sync[SYNC_STAGES-1] & ~sig_prev;

  // Handshake: start is a request sampled only in IDLE; busy covers ARM..PERIOD,
  // and valid is a one-cycle pulse in DONE carrying delay/period/err.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    d_nxt     = d_q;
    p_nxt     = p_q;
    flag_nxt  = flag_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ARM;
          cnt_nxt   = '0;
          d_nxt     = '0;
          p_nxt     = '0;
          flag_nxt  = 1'b0;
        end
      end
      ARM: begin
        if (rise_ref) begin
          cnt_nxt = '0;
          if (rise_sig) begin
            d_nxt     = '0;
            state_nxt = PERIOD;
          end else begin
            state_nxt = MEASURE;
          end
        end
      end
      MEASURE: begin
        if (cnt == CTR_MAX) begin
          flag_nxt  = 1'b1;
          d_nxt     = CTR_MAX;
          p_nxt     = CTR_MAX;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
          // A second ref edge before the sig edge means delay >= period.
          if (rise_ref) begin
            flag_nxt  = 1'b1;
            d_nxt     = '0;
            p_nxt     = cnt + 1'b1;
            state_nxt = DONE;
          end else if (rise_sig) begin
            d_nxt     = cnt + 1'b1;
            state_nxt = PERIOD;
          end
        end
      end
      PERIOD: begin
        if (cnt == CTR_MAX) begin
          flag_nxt  = 1'b1;
          p_nxt     = CTR_MAX;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
          if (rise_ref) begin
            p_nxt     = cnt + 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      d_q    <= '0;
      p_q    <= '0;
      flag_q <= 1'b0;
      delay  <= '0;
      period <= '0;
      err    <= 1'b0;
      valid  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      d_q    <= d_nxt;
      p_q    <= p_nxt;
      flag_q <= flag_nxt;
      busy   <= (state_nxt == ARM) || (state_nxt == MEASURE) || (state_nxt == PERIOD);
      valid  <= (state_nxt == DONE);
      if (state_nxt == DONE) begin
        delay  <= d_nxt;
        period <= p_nxt;
        err    <= flag_nxt;
      end
    end
  end

endmodule

// File: tb/tb_phase_delay_meter.sv
// Bench for phase_delay_meter: a wide-counter and a narrow-counter instance are
// driven by a shared PWM generator and compared against an edge-time model.
module tb_phase_delay_meter;

  localparam int W1 = 18;
  localparam int W2 = 10;

  logic          clk;
  logic          rst;
  logic          ref_in, sig_in;
  logic          start1, start2;
  logic          busy1, valid1, err1;
  logic          busy2, valid2, err2;
  logic [W1-1:0] delay1, period1;
  logic [W2-1:0] delay2, period2;

  int            n_cmp  = 0;
  int            n_fail = 0;
  int unsigned   cyc    = 0;
  int            nv1    = 0;
  int            nv2    = 0;

  bit            wave_on   = 0;
  bit            sig_stuck = 0;
  int            w0 = 0, wp = 1000, wh = 500, wd = 0;

  phase_delay_meter #(.CTR_W(W1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst(rst), .ref_in(ref_in), .sig_in(sig_in), .start(start1),
    .busy(busy1), .delay(delay1), .period(period1), .valid(valid1), .err(err1)
  );

  phase_delay_meter #(.CTR_W(W2), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .ref_in(ref_in), .sig_in(sig_in), .start(start2),
    .busy(busy2), .delay(delay2), .period(period2), .valid(valid2), .err(err2)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // PWM generator: ref rises at w0 + n*wp, sig is ref delayed by wd cycles.
  initial begin
    ref_in = 1'b0;
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      if (!wave_on) begin
        ref_in = 1'b0;
        sig_in = 1'b0;
      end else begin
        int tau;
        tau    = int'(cyc) - w0;
        ref_in = (tau >= 0) && ((tau % wp) < wh);
        sig_in = !sig_stuck && (tau >= wd) && (((tau - wd) % wp) < wh);
      end
    end
  end

  // valid-cycle counters
  initial begin
    forever begin
      @(negedge clk);
      if (valid1 === 1'b1) nv1++;
      if (valid2 === 1'b1) nv2++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int get_nv(input int sel);
    return (sel == 1) ? nv1 : nv2;
  endfunction

  function automatic logic [31:0] get_delay(input int sel);
    logic [31:0] v;
    v = (sel == 1) ? 32'(delay1) : 32'(delay2);
    return v;
  endfunction

  function automatic logic [31:0] get_period(input int sel);
    logic [31:0] v;
    v = (sel == 1) ? 32'(period1) : 32'(period2);
    return v;
  endfunction

  function automatic logic [31:0] get_err(input int sel);
    return (sel == 1) ? 32'(err1) : 32'(err2);
  endfunction

  function automatic logic [31:0] get_busy(input int sel);
    return (sel == 1) ? 32'(busy1) : 32'(busy2);
  endfunction

  task automatic set_start(input int sel, input bit v);
    if (sel == 1) start1 = v;
    else          start2 = v;
  endtask

  // Reference model on edge times relative to the first armed ref edge (r0):
  // next ref edge r1, first sig edge s at or after r0; counts saturate at maxv.
  function automatic void model(input int p, input int d, input bit stuck, input int maxv,
                                output int ed, output int ep, output bit ee);
    int r0, r1, s;
    r0 = 0;
    r1 = p;
    s  = stuck ? 32'h7fff_ffff : d;
    if (s == r0 || (s < r1 && (s - r0) <= maxv)) begin
      ed = s - r0;
      if ((r1 - r0) <= maxv) begin ep = r1 - r0; ee = 1'b0; end
      else                   begin ep = maxv;    ee = 1'b1; end
    end else if ((r1 - r0) <= maxv) begin
      ed = 0; ep = r1 - r0; ee = 1'b1;
    end else begin
      ed = maxv; ep = maxv; ee = 1'b1;
    end
  endfunction

  task automatic wait_valid(input int sel, input int base, input int target,
                            input int budget, input bit nag);
    int waited;
    waited = 0;
    while ((get_nv(sel) - base) < target && waited < budget) begin
      set_start(sel, nag && (waited % 37 == 5));
      @(posedge clk); #1;
      waited++;
    end
    set_start(sel, 1'b0);
  endtask

  task automatic run_meas(input int sel, input int p, input int h, input int d,
                          input bit stuck, input bit nag, input bit again, input string tag);
    int maxv, ed, ep, base, budget;
    bit ee;
    maxv   = (sel == 1) ? (1 << W1) - 1 : (1 << W2) - 1;
    budget = 3 * p + 2500;
    model(p, d, stuck, maxv, ed, ep, ee);
    wave_on = 0;
    set_start(sel, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    base = get_nv(sel);
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    check({tag, "_busy_on"}, get_busy(sel), 1);
    wp = p; wh = h; wd = d; sig_stuck = stuck;
    w0 = int'(cyc) + 3;
    wave_on = 1;
    wait_valid(sel, base, 1, budget, nag);
    check({tag, "_valid"}, get_nv(sel) - base, 1);
    check({tag, "_delay"}, get_delay(sel), ed);
    check({tag, "_period"}, get_period(sel), ep);
    check({tag, "_err"}, get_err(sel), 32'(ee));
    check({tag, "_busy_off"}, get_busy(sel), 0);
    if (again) begin
      set_start(sel, 1'b1);
      @(posedge clk); #1;
      set_start(sel, 1'b0);
      check({tag, "_busy_again"}, get_busy(sel), 1);
      wait_valid(sel, base, 2, budget, 1'b0);
      check({tag, "_valid_again"}, get_nv(sel) - base, 2);
      check({tag, "_delay_again"}, get_delay(sel), ed);
      check({tag, "_period_again"}, get_period(sel), ep);
      check({tag, "_err_again"}, get_err(sel), 32'(ee));
    end
    repeat (20) @(posedge clk);
    #1;
    check({tag, "_valid_count"}, get_nv(sel) - base, again ? 2 : 1);
  endtask

  initial begin
    int base, p, h, d;
    rst    = 1'b1;
    start1 = 1'b0;
    start2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy1), 0);
    check("rst_valid", 32'(valid1), 0);
    check("rst_err", 32'(err1), 0);
    check("rst_delay", 32'(delay1), 0);
    check("rst_period", 32'(period1), 0);
    check("rst_busy2", 32'(busy2), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run_meas(1, 1000, 500, 343, 0, 0, 0, "nominal");
    run_meas(1, 1000, 500, 0, 0, 0, 0, "zero_delay");
    run_meas(1, 1000, 500, 1324, 0, 0, 0, "long_delay");
    run_meas(1, 600, 300, 600, 0, 0, 0, "delay_eq_period");
    run_meas(1, 600, 300, 599, 0, 0, 0, "delay_period_m1");
    run_meas(2, 1500, 750, 0, 1, 0, 0, "stuck_sig");
    run_meas(1, 1000, 500, 343, 0, 1, 1, "handshake");

    // asynchronous reset in the middle of a measurement
    wave_on = 0;
    repeat (8) @(posedge clk);
    #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    wp = 1000; wh = 500; wd = 600; sig_stuck = 0;
    w0 = int'(cyc) + 3;
    wave_on = 1;
    repeat (200) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy1), 0);
    check("midrst_valid", 32'(valid1), 0);
    check("midrst_err", 32'(err1), 0);
    check("midrst_delay", 32'(delay1), 0);
    check("midrst_period", 32'(period1), 0);
    @(posedge clk); #1;
    rst  = 1'b0;
    base = nv1;
    repeat (2500) @(posedge clk);
    #1;
    check("midrst_no_valid", nv1 - base, 0);

    for (int i = 0; i < 6; i++) begin
      p = $urandom_range(200, 1200);
      h = $urandom_range(1, p - 1);
      d = $urandom_range(0, 2 * p);
      run_meas(1, p, h, d, 0, 0, 0, $sformatf("rand1_%0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      p = $urandom_range(300, 1300);
      h = $urandom_range(1, p - 1);
      d = $urandom_range(0, p + 200);
      run_meas(2, p, h, d, 0, 0, 0, $sformatf("rand2_%0d", i));
    end

    wave_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_delay_meter.md
Name: phase_delay_meter

Overview:
- Receive-side counterpart of the phased shift-register delay line: measures the delay in clk cycles between a reference PWM (ref_in, e.g. pwm_in) and one delayed tap or returned channel (sig_in), plus the reference period.
- Single-shot measurement armed by `start`; results are held in registers for the LED/serial/debug logic in mojo_top.
- Used to verify the programmed per-channel delays, for example 343 or 662 cycles per channel step.

Parameters:
- CTR_W, 18, width of the delay/period counters and result ports; saturation value is 2^CTR_W-1.
- SYNC_STAGES, 2, flip-flop synchronizer depth applied to ref_in and sig_in; minimum 2.

Ports:
- clk  in  1  50 MHz system clock.
- rst  in  1  reset, asynchronous, active-high.
- ref_in  in  1  reference PWM; asynchronous to clk.
- sig_in  in  1  delayed PWM under measurement; asynchronous to clk.
- start  in  1  one-cycle request to begin a measurement; ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until the cycle valid is asserted.
- delay  out  CTR_W  cycles from ref rising edge to the first following sig rising edge.
- period  out  CTR_W  cycles between two consecutive ref rising edges.
- valid  out  1  one-cycle pulse when delay/period/err are updated.
- err  out  1  set with valid when the measurement is invalid (see below); held until the next valid.

Behaviour:
- Reset (async, active-high): all synchronizer flops 0, state IDLE, counters 0, delay=0, period=0, valid=0, err=0, busy=0.
- Synchronization:
  - ref_in and sig_in each pass through SYNC_STAGES flops, then a 1-flop edge detector.
  - rise_x = sync_x & ~prev_x.
  - Both paths have identical latency, so measured values are exact cycle differences.
- FSM states: IDLE, ARM, MEASURE, PERIOD, DONE.
- IDLE: on start=1 go to ARM with busy=1 next cycle, cnt=0.
- ARM: wait for rise_ref.
  - On rise_ref: cnt<=0, go to MEASURE.
  - If rise_sig occurs in the same cycle: record delay=0 and go directly to PERIOD.
  - rise_sig without rise_ref is ignored.
- MEASURE: cnt increments by 1 each cycle.
  - On rise_sig: latch d=cnt+1 (cycles since the ref edge) and go to PERIOD; cnt keeps running.
  - If rise_ref occurs before or in the same cycle as rise_sig: delay >= period, which is an error. Set err flag, latch p=cnt+1, go to DONE with d=0.
- PERIOD: cnt keeps incrementing.
  - On rise_ref: latch p=cnt+1, go to DONE.
  - Further rise_sig is ignored.
- Saturation: if cnt reaches 2^CTR_W-1 in MEASURE or PERIOD (missing edge or stuck input):
  - err=1; delay and period outputs = all-ones for any value not yet captured.
  - Go to DONE. No wrap-around is permitted.
- DONE, one cycle:
  - delay<=d, period<=p, err<=flag, valid=1, busy<=0.
  - Return to IDLE.
- valid is high exactly one cycle per accepted start. Outputs are stable between valid pulses.
- start in the DONE cycle is ignored; start in IDLE the cycle after DONE is accepted.
- Latency: valid asserts 1 cycle after the internal detection of the closing ref edge.
- rst mid-measurement: immediate return to reset values; no valid is emitted.

Test Plan:
- Reset values: assert rst asynchronously mid-MEASURE -> busy, valid, err, delay, period all 0 immediately; no valid pulse after release.
- Nominal: ref period 1000 cycles (500 high), sig = ref delayed 343 cycles, pulse start -> single valid with delay=343, period=1000, err=0; busy high for <=2 periods.
- Zero delay: sig identical to ref, start -> delay=0, period=1000, err=0.
- Delay longer than period: ref period 1000, sig delayed 1324 -> valid with err=1, delay=0, period=1000.
- Stuck input: ref toggling, sig held 0, CTR_W=10 -> err=1, delay=1023, period=1023, single valid.
- Handshake: start pulsed repeatedly while busy -> exactly one valid; start on the cycle after valid -> second valid with identical results.
